// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU definitions: operand width, ALU_* operation codes and the
// single-cycle datapath function used by the execution unit.
package alu_exec_unit_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  // Operation codes driven by the ALU control unit; 12..15 are undefined.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_NOP  = 4'd11;

  function automatic logic alu_is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  function automatic logic alu_is_legal(input logic [3:0] sel);
    return sel <= ALU_NOP;
  endfunction

  // Non-shift operations; shifts and undefined codes yield 0 here.
  function automatic logic [XLEN-1:0] alu_logic(input logic [3:0] sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (sel)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_PASS: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter. Loaded on start_i, then
// shifts work_q once per cycle while cnt_q counts down. done_o is high in
// the cycle whose edge completes the last step; result_o is that final value.
module alu_serial_shifter
  import alu_exec_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [3:0]         op_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  logic [XLEN-1:0]    work_q, work_d, work_step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;

  // One-bit step in the latched direction; arithmetic right fills with sign.
  always_comb begin
    work_step = left_q ? {work_q[XLEN-2:0], 1'b0}
                       : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
  end

  assign done_o   = (cnt_q == SHAMT_W'(1));
  assign result_o = work_step;

  // Load on start, otherwise step while the counter is non-zero.
  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (start_i) begin
      work_d  = data_i;
      cnt_d   = shamt_i;
      left_d  = (op_i == ALU_SLL);
      arith_d = (op_i == ALU_SRA);
    end else if (cnt_q != '0) begin
      work_d = work_step;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  // Shifter state registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execution-stage ALU with registered result,
// zero and illegal flags. Optional macro ALU_BARREL_SHIFT_EN selects a
// single-cycle barrel shifter; otherwise shifts use alu_serial_shifter.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
`endif

  state_t             state_q;
  logic [XLEN-1:0]    result_q;
  logic               zero_q, illegal_q, out_valid_q;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    imm_result;

  // DONE accepts a new request only in the cycle its result drains.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHAMT_W-1:0];

  // Result for every operation that finishes in the accept cycle.
  always_comb begin
    imm_result = alu_logic(alu_sel, op_a, op_b);
    case (alu_sel)
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: imm_result = op_a << shamt;
      ALU_SRL: imm_result = op_a >> shamt;
      ALU_SRA: imm_result = $signed(op_a) >>> shamt;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: imm_result = op_a;  // only reached with shamt == 0
`endif
      default: ;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic            start_shift;
  logic            shift_done;
  logic [XLEN-1:0] shift_result;

  assign start_shift = accept && alu_is_shift(alu_sel) && (shamt != '0);

  alu_serial_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_shift),
    .op_i     (alu_sel),
    .data_i   (op_a),
    .shamt_i  (shamt),
    .done_o   (shift_done),
    .result_o (shift_result)
  );
`endif

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (start_shift) begin
        state_q     <= ST_SHIFT;
        out_valid_q <= 1'b0;
      end else
`endif
      begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= imm_result;
        zero_q      <= (imm_result == '0);
        illegal_q   <= !alu_is_legal(alu_sel);
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    end else if ((state_q == ST_SHIFT) && shift_done) begin
      state_q     <= ST_DONE;
      out_valid_q <= 1'b1;
      result_q    <= shift_result;
      zero_q      <= (shift_result == '0);
      illegal_q   <= 1'b0;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (default and ALU_BARREL_SHIFT_EN builds).
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a, op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %-22s observed=%08h expected=%08h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, wait (bounded) for the result, drain it.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_sel   = sel;
    op_a      = a;
    op_b      = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, result, exp_res);
    @(negedge clk);
  endtask

  int lat, busy, stale;
  int exp_lat, exp_busy;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_sel = ALU_NOP; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_result",    result,             32'd0);
    check("rst_zero",      {31'd0, zero},      32'd0);
    check("rst_illegal",   {31'd0, illegal},   32'd0);

    // ADD 5+7, latency 1, then backpressure for 3 cycles
    in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 32'd5; op_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("add_lat1_valid", {31'd0, out_valid}, 32'd1);
    check("add_result",     result,             32'd12);
    check("add_zero",       {31'd0, zero},      32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result",   result,             32'd12);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
    end

    // Drain and accept XOR in the same cycle
    out_ready = 1'b1; in_valid = 1'b1; alu_sel = ALU_XOR; op_a = 32'hF0; op_b = 32'hFF;
    #1;
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("xor_valid",  {31'd0, out_valid}, 32'd1);
    check("xor_result", result,             32'h0F);
    @(negedge clk);
    check("drain_idle_valid", {31'd0, out_valid}, 32'd0);
    check("drain_idle_ready", {31'd0, in_ready},  32'd1);

    // Back-to-back SUB, SLTU, SLT with out_ready high
    in_valid = 1'b1; alu_sel = ALU_SUB; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    check("sub_result", result,        32'd0);
    check("sub_zero",   {31'd0, zero}, 32'd1);
    alu_sel = ALU_SLTU; op_a = 32'd1; op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("sltu_valid",  {31'd0, out_valid}, 32'd1);
    check("sltu_result", result,             32'd1);
    alu_sel = ALU_SLT;
    @(negedge clk);
    in_valid = 1'b0;
    check("slt_result", result,        32'd0);
    check("slt_zero",   {31'd0, zero}, 32'd1);
    @(negedge clk);

    // More operations
    run_op("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd1,   32'd0);
    run_op("and",      ALU_AND,  32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
    run_op("or",       ALU_OR,   32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF);
    run_op("sll_2",    ALU_SLL,  32'd3,         32'd2,   32'd12);
    run_op("srl_3",    ALU_SRL,  32'h80,        32'd3,   32'h10);
    run_op("sll_0",    ALU_SLL,  32'h1234_5678, 32'd0,   32'h1234_5678);
    run_op("nop",      ALU_NOP,  32'd9,         32'd9,   32'd0);

    // SRA 0x80000000 >>> 4, measure latency and busy cycles
`ifdef ALU_BARREL_SHIFT_EN
    exp_lat = 1; exp_busy = 0;
`else
    exp_lat = 5; exp_busy = 4;
`endif
    out_ready = 1'b1; in_valid = 1'b1; alu_sel = ALU_SRA; op_a = 32'h8000_0000; op_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    check("sra_latency",  lat,    exp_lat);
    check("sra_busy",     busy,   exp_busy);
    check("sra_result",   result, 32'hF800_0000);
    @(negedge clk);

    // SLL by 31, reset asserted mid-operation
    in_valid = 1'b1; alu_sel = ALU_SLL; op_a = 32'd1; op_b = 32'd31;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid",    {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready},  32'd1);
    check("abort_result",   result,             32'd0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("abort_no_stale", stale, 32'd0);

    // Illegal code followed by PASS
    in_valid = 1'b1; alu_sel = 4'b1111; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    check("ill_result",  result,           32'd0);
    check("ill_illegal", {31'd0, illegal}, 32'd1);
    check("ill_zero",    {31'd0, zero},    32'd1);
    alu_sel = ALU_PASS; op_b = 32'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("pass_result",  result,           32'h1234);
    check("pass_illegal", {31'd0, illegal}, 32'd0);
    check("pass_zero",    {31'd0, zero},    32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
